operand_collector: RTL and testbench

Four-entry operand collector between the register-allocation unit (RAU) and the execution stage. The RAU allocates an entry per issued instruction. The entry then captures source operands as the four banked register-file outputs return them, tagged with entry number and source number. When an entry holds every operand it needs, it competes for a single issue port toward the execution unit. The entry is freed when the execution unit accepts it.

---
 rtl/gpgpu_oc_pkg.sv | 30 +++
 rtl/oc_issue_arb.sv | 81 ++++++++
 rtl/operand_collector.sv | 185 ++++++++++++++++++
 tb/tb_operand_collector.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpgpu_oc_pkg.sv
// Shared types and sizes for the operand collector and its issue arbiter.
// No logic and no latency; the entry state is derived from busy and the ready bits.
// Backpressure: none.
package gpgpu_oc_pkg;

  localparam int NUM_ENTRY = 4;
  localparam int DATA_W    = 256;
  localparam int PAYLOAD_W = 48;
  localparam int ENTRY_W   = 2;

  typedef enum logic [1:0] {
    FREE    = 2'd0,
    COLLECT = 2'd1,
    READY   = 2'd2
  } oc_state_e;

  typedef struct packed {
    logic                 busy;
    logic                 s1_rdy;
    logic                 s2_rdy;
    logic [PAYLOAD_W-1:0] payload;
  } oc_entry_t;

  function automatic oc_state_e oc_state_of(input oc_entry_t e);
    if (!e.busy) return FREE;
    if (e.s1_rdy && e.s2_rdy) return READY;
    return COLLECT;
  endfunction

endpackage

// File: rtl/oc_issue_arb.sv
// Picks one ready entry per cycle: fixed lowest-index priority, or round-robin with OC_RR_ARB_EN.
// Latency: combinational grant from req_i and registered lock/pointer state.
// Backpressure: a grant not accepted (ex_rdy_i low) is locked and held until accepted.
module oc_issue_arb
  import gpgpu_oc_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_ENTRY-1:0] req_i,
  input  logic                 ex_rdy_i,
  output logic                 gnt_vld_o,
  output logic [ENTRY_W-1:0]   gnt_idx_o
);

  logic               lock_vld_q, lock_vld_d;
  logic [ENTRY_W-1:0] lock_idx_q, lock_idx_d;
  logic               pick_vld;
  logic [ENTRY_W-1:0] pick_idx;

`ifdef OC_RR_ARB_EN
  logic [ENTRY_W-1:0] ptr_q, ptr_d;
  logic [ENTRY_W-1:0] cand;

  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int i = 0; i < NUM_ENTRY; i++) begin
      cand = ptr_q + ENTRY_W'(i);
      if (!pick_vld && req_i[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_vld_o && ex_rdy_i) ptr_d = gnt_idx_o + ENTRY_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
`else
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int i = NUM_ENTRY - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        pick_vld = 1'b1;
        pick_idx = ENTRY_W'(i);
      end
    end
  end
`endif

  // An offered entry stays granted until the execution unit takes it.
  assign gnt_vld_o = lock_vld_q | pick_vld;
  assign gnt_idx_o = lock_vld_q ? lock_idx_q : pick_idx;

  always_comb begin
    lock_vld_d = gnt_vld_o && !ex_rdy_i;
    lock_idx_d = gnt_idx_o;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_vld_q <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      lock_vld_q <= lock_vld_d;
      lock_idx_q <= lock_idx_d;
    end
  end

  a_lock_has_req: assert property (@(posedge clk) disable iff (!rst_n)
    lock_vld_q |-> req_i[lock_idx_q]);

endmodule

// File: rtl/operand_collector.sv
// Four-entry operand collector: RAU allocation, per-bank RF operand capture, one issue port (OC_RR_ARB_EN selects round-robin).
// Latency: alloc or capture at edge T is visible from T+1; issue data is combinational from entry registers.
// Backpressure: EX_Ready low holds the offered entry and its outputs stable; OC_Full blocks the RAU.
module operand_collector
  import gpgpu_oc_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 RAU_Alloc,
  input  logic                 RAU_Src1_Req,
  input  logic                 RAU_Src2_Req,
  input  logic [PAYLOAD_W-1:0] RAU_Payload,
  output logic [ENTRY_W-1:0]   OC_Free_EntryNum,
  output logic                 OC_Full,
  input  logic [DATA_W-1:0]    RF_Out_Bank0,
  input  logic [DATA_W-1:0]    RF_Out_Bank1,
  input  logic [DATA_W-1:0]    RF_Out_Bank2,
  input  logic [DATA_W-1:0]    RF_Out_Bank3,
  input  logic [ENTRY_W-1:0]   RF_Bank0_EntryNum_OC,
  input  logic [ENTRY_W-1:0]   RF_Bank1_EntryNum_OC,
  input  logic [ENTRY_W-1:0]   RF_Bank2_EntryNum_OC,
  input  logic [ENTRY_W-1:0]   RF_Bank3_EntryNum_OC,
  input  logic [3:0]           RF_Dout_Valid,
  input  logic [3:0]           RF_SrcNum_OC,
  output logic                 OC_Issue_Valid,
  input  logic                 EX_Ready,
  output logic [ENTRY_W-1:0]   OC_Issue_EntryNum,
  output logic [DATA_W-1:0]    OC_Issue_Src1,
  output logic [DATA_W-1:0]    OC_Issue_Src2,
  output logic [PAYLOAD_W-1:0] OC_Issue_Payload
);

  oc_entry_t           ent_q [NUM_ENTRY];
  oc_entry_t           ent_d [NUM_ENTRY];
  logic [DATA_W-1:0]   s1_q  [NUM_ENTRY];
  logic [DATA_W-1:0]   s1_d  [NUM_ENTRY];
  logic [DATA_W-1:0]   s2_q  [NUM_ENTRY];
  logic [DATA_W-1:0]   s2_d  [NUM_ENTRY];

  logic [DATA_W-1:0]   rf_dat [4];
  logic [ENTRY_W-1:0]  rf_ent [4];

  logic [NUM_ENTRY-1:0] busy_vec, rdy_vec;
  logic                 free_vld;
  logic [ENTRY_W-1:0]   free_idx;
  logic                 alloc_fire, issue_fire;
  logic                 iss_vld;
  logic [ENTRY_W-1:0]   iss_idx;

  logic [2:0]           n1 [NUM_ENTRY];
  logic [2:0]           n2 [NUM_ENTRY];
  logic [1:0]           cap1_bank [NUM_ENTRY];
  logic [1:0]           cap2_bank [NUM_ENTRY];
  logic [NUM_ENTRY-1:0] cap1_ok, cap2_ok;
  logic                 dup_err, free_err, rdy_err;

  assign rf_dat[0] = RF_Out_Bank0;
  assign rf_dat[1] = RF_Out_Bank1;
  assign rf_dat[2] = RF_Out_Bank2;
  assign rf_dat[3] = RF_Out_Bank3;
  assign rf_ent[0] = RF_Bank0_EntryNum_OC;
  assign rf_ent[1] = RF_Bank1_EntryNum_OC;
  assign rf_ent[2] = RF_Bank2_EntryNum_OC;
  assign rf_ent[3] = RF_Bank3_EntryNum_OC;

  always_comb begin
    for (int e = 0; e < NUM_ENTRY; e++) begin
      busy_vec[e] = ent_q[e].busy;
      rdy_vec[e]  = (oc_state_of(ent_q[e]) == READY);
    end
  end

  always_comb begin
    free_vld = 1'b0;
    free_idx = '0;
    for (int e = NUM_ENTRY - 1; e >= 0; e--) begin
      if (!busy_vec[e]) begin
        free_vld = 1'b1;
        free_idx = ENTRY_W'(e);
      end
    end
  end

  assign OC_Full          = &busy_vec;
  assign OC_Free_EntryNum = free_idx;
  assign alloc_fire       = RAU_Alloc && free_vld;

  // Capture demux: a field is written only with exactly one legal hit.
  always_comb begin
    dup_err  = 1'b0;
    free_err = 1'b0;
    rdy_err  = 1'b0;
    cap1_ok  = '0;
    cap2_ok  = '0;
    for (int e = 0; e < NUM_ENTRY; e++) begin
      n1[e]        = '0;
      n2[e]        = '0;
      cap1_bank[e] = '0;
      cap2_bank[e] = '0;
      for (int b = 0; b < 4; b++) begin
        if (RF_Dout_Valid[b] && (rf_ent[b] == ENTRY_W'(e))) begin
          if (RF_SrcNum_OC[b]) begin
            n2[e]        = n2[e] + 3'd1;
            cap2_bank[e] = 2'(b);
          end else begin
            n1[e]        = n1[e] + 3'd1;
            cap1_bank[e] = 2'(b);
          end
        end
      end
      cap1_ok[e] = (n1[e] == 3'd1) && ent_q[e].busy && !ent_q[e].s1_rdy;
      cap2_ok[e] = (n2[e] == 3'd1) && ent_q[e].busy && !ent_q[e].s2_rdy;
      dup_err    = dup_err | (n1[e] > 3'd1) | (n2[e] > 3'd1);
      free_err   = free_err | (((n1[e] != 3'd0) || (n2[e] != 3'd0)) && !ent_q[e].busy);
      rdy_err    = rdy_err | ((n1[e] != 3'd0) && ent_q[e].busy && ent_q[e].s1_rdy)
                           | ((n2[e] != 3'd0) && ent_q[e].busy && ent_q[e].s2_rdy);
    end
  end

  oc_issue_arb u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (rdy_vec),
    .ex_rdy_i  (EX_Ready),
    .gnt_vld_o (iss_vld),
    .gnt_idx_o (iss_idx)
  );

  assign issue_fire = iss_vld && EX_Ready;

  always_comb begin
    ent_d = ent_q;
    s1_d  = s1_q;
    s2_d  = s2_q;
    for (int e = 0; e < NUM_ENTRY; e++) begin
      if (issue_fire && (iss_idx == ENTRY_W'(e))) begin
        ent_d[e].busy   = 1'b0;
        ent_d[e].s1_rdy = 1'b0;
        ent_d[e].s2_rdy = 1'b0;
      end
      if (cap1_ok[e]) begin
        ent_d[e].s1_rdy = 1'b1;
        s1_d[e]         = rf_dat[cap1_bank[e]];
      end
      if (cap2_ok[e]) begin
        ent_d[e].s2_rdy = 1'b1;
        s2_d[e]         = rf_dat[cap2_bank[e]];
      end
      if (alloc_fire && (free_idx == ENTRY_W'(e))) begin
        ent_d[e].busy    = 1'b1;
        ent_d[e].s1_rdy  = !RAU_Src1_Req;
        ent_d[e].s2_rdy  = !RAU_Src2_Req;
        ent_d[e].payload = RAU_Payload;
        s1_d[e]          = '0;
        s2_d[e]          = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int e = 0; e < NUM_ENTRY; e++) begin
        ent_q[e] <= '0;
        s1_q[e]  <= '0;
        s2_q[e]  <= '0;
      end
    end else begin
      ent_q <= ent_d;
      s1_q  <= s1_d;
      s2_q  <= s2_d;
    end
  end

  assign OC_Issue_Valid    = iss_vld;
  assign OC_Issue_EntryNum = iss_vld ? iss_idx : '0;
  assign OC_Issue_Src1     = iss_vld ? s1_q[iss_idx] : '0;
  assign OC_Issue_Src2     = iss_vld ? s2_q[iss_idx] : '0;
  assign OC_Issue_Payload  = iss_vld ? ent_q[iss_idx].payload : '0;

  a_no_dup_capture:  assert property (@(posedge clk) disable iff (!rst_n) !dup_err);
  a_no_free_capture: assert property (@(posedge clk) disable iff (!rst_n) !free_err);
  a_no_rdy_capture:  assert property (@(posedge clk) disable iff (!rst_n) !rdy_err);
  a_no_alloc_full:   assert property (@(posedge clk) disable iff (!rst_n) !(RAU_Alloc && OC_Full));

endmodule

// File: tb/tb_operand_collector.sv
// Scoreboard bench for operand_collector; issue order expectations follow OC_RR_ARB_EN.
module tb_operand_collector;
  import gpgpu_oc_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 RAU_Alloc = 1'b0;
  logic                 RAU_Src1_Req = 1'b0;
  logic                 RAU_Src2_Req = 1'b0;
  logic [PAYLOAD_W-1:0] RAU_Payload = '0;
  logic [ENTRY_W-1:0]   OC_Free_EntryNum;
  logic                 OC_Full;
  logic [DATA_W-1:0]    rf_dat [4];
  logic [ENTRY_W-1:0]   rf_ent [4];
  logic [3:0]           RF_Dout_Valid = '0;
  logic [3:0]           RF_SrcNum_OC = '0;
  logic                 OC_Issue_Valid;
  logic                 EX_Ready = 1'b0;
  logic [ENTRY_W-1:0]   OC_Issue_EntryNum;
  logic [DATA_W-1:0]    OC_Issue_Src1, OC_Issue_Src2;
  logic [PAYLOAD_W-1:0] OC_Issue_Payload;

  typedef struct {
    logic [ENTRY_W-1:0]   ent;
    logic [DATA_W-1:0]    s1;
    logic [DATA_W-1:0]    s2;
    logic [PAYLOAD_W-1:0] pl;
  } exp_t;
  exp_t sb_q[$];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  operand_collector dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .RAU_Alloc            (RAU_Alloc),
    .RAU_Src1_Req         (RAU_Src1_Req),
    .RAU_Src2_Req         (RAU_Src2_Req),
    .RAU_Payload          (RAU_Payload),
    .OC_Free_EntryNum     (OC_Free_EntryNum),
    .OC_Full              (OC_Full),
    .RF_Out_Bank0         (rf_dat[0]),
    .RF_Out_Bank1         (rf_dat[1]),
    .RF_Out_Bank2         (rf_dat[2]),
    .RF_Out_Bank3         (rf_dat[3]),
    .RF_Bank0_EntryNum_OC (rf_ent[0]),
    .RF_Bank1_EntryNum_OC (rf_ent[1]),
    .RF_Bank2_EntryNum_OC (rf_ent[2]),
    .RF_Bank3_EntryNum_OC (rf_ent[3]),
    .RF_Dout_Valid        (RF_Dout_Valid),
    .RF_SrcNum_OC         (RF_SrcNum_OC),
    .OC_Issue_Valid       (OC_Issue_Valid),
    .EX_Ready             (EX_Ready),
    .OC_Issue_EntryNum    (OC_Issue_EntryNum),
    .OC_Issue_Src1        (OC_Issue_Src1),
    .OC_Issue_Src2        (OC_Issue_Src2),
    .OC_Issue_Payload     (OC_Issue_Payload)
  );

  task automatic check(input string tag, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] dpat(input int e, input int s);
    logic [31:0] w;
    w = 32'hD000_0000 | 32'(e << 8) | 32'(s);
    return {8{w}};
  endfunction

  function automatic logic [PAYLOAD_W-1:0] pl(input int k);
    return 48'hC0DE_0000_0000 | 48'(k);
  endfunction

  task automatic push(input int e, input logic [DATA_W-1:0] s1, input logic [DATA_W-1:0] s2,
                      input logic [PAYLOAD_W-1:0] p);
    exp_t x;
    x.ent = ENTRY_W'(e);
    x.s1  = s1;
    x.s2  = s2;
    x.pl  = p;
    sb_q.push_back(x);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    RAU_Alloc     = 1'b0;
    RF_Dout_Valid = '0;
  endtask

  task automatic alloc(input bit r1, input bit r2, input logic [PAYLOAD_W-1:0] p);
    RAU_Alloc    = 1'b1;
    RAU_Src1_Req = r1;
    RAU_Src2_Req = r2;
    RAU_Payload  = p;
  endtask

  task automatic rf_set(input int b, input int e, input bit src, input logic [DATA_W-1:0] d);
    rf_dat[b]        = d;
    rf_ent[b]        = ENTRY_W'(e);
    RF_SrcNum_OC[b]  = src;
    RF_Dout_Valid[b] = 1'b1;
  endtask

  task automatic issue_one();
    EX_Ready = 1'b1;
    cyc();
    EX_Ready = 1'b0;
  endtask

  // Each accepted transfer is compared against the oldest expected issue.
  always @(negedge clk) begin
    if (rst_n && OC_Issue_Valid && EX_Ready) begin
      if (sb_q.size() == 0) begin
        check("sb_underflow", 1, 0);
      end else begin
        exp_t x;
        x = sb_q.pop_front();
        check("iss_entry", OC_Issue_EntryNum, x.ent);
        check("iss_src1", OC_Issue_Src1, x.s1);
        check("iss_src2", OC_Issue_Src2, x.s2);
        check("iss_payload", OC_Issue_Payload, x.pl);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA_W-1:0] pat_a, pat_5;
    pat_a = {64{4'hA}};
    pat_5 = {64{4'h5}};
    for (int b = 0; b < 4; b++) begin
      rf_dat[b] = '0;
      rf_ent[b] = '0;
    end

    repeat (2) @(posedge clk);
    #1;
    check("rst_full", OC_Full, 0);
    check("rst_free", OC_Free_EntryNum, 0);
    check("rst_valid", OC_Issue_Valid, 0);
    check("rst_entry", OC_Issue_EntryNum, 0);
    check("rst_src1", OC_Issue_Src1, 0);
    check("rst_src2", OC_Issue_Src2, 0);
    check("rst_payload", OC_Issue_Payload, 0);
    rst_n = 1'b1;
    cyc();

    // Two-source collect with captures two cycles apart.
    alloc(1, 1, pl(0));
    cyc();
    check("t1_free", OC_Free_EntryNum, 1);
    check("t1_valid_alloc", OC_Issue_Valid, 0);
    rf_set(2, 0, 0, pat_a);
    cyc();
    check("t1_valid_half", OC_Issue_Valid, 0);
    cyc();
    rf_set(1, 0, 1, pat_5);
    cyc();
    check("t1_valid", OC_Issue_Valid, 1);
    check("t1_src1", OC_Issue_Src1, pat_a);
    check("t1_src2", OC_Issue_Src2, pat_5);
    push(0, pat_a, pat_5, pl(0));
    issue_one();
    check("t1_valid_after", OC_Issue_Valid, 0);
    check("t1_free_after", OC_Free_EntryNum, 0);

    // No sources requested; issue next cycle while entry 1 is allocated alongside.
    alloc(0, 0, pl(1));
    cyc();
    check("t2_valid", OC_Issue_Valid, 1);
    check("t2_src1", OC_Issue_Src1, 0);
    check("t2_src2", OC_Issue_Src2, 0);
    push(0, '0, '0, pl(1));
    alloc(1, 1, pl(2));
    issue_one();
    check("t2_free", OC_Free_EntryNum, 0);
    check("t2_valid_after", OC_Issue_Valid, 0);

    // Fill, then issue entry 2.
    alloc(1, 1, pl(10));
    cyc();
    check("t3_free_a", OC_Free_EntryNum, 2);
    alloc(1, 1, pl(12));
    cyc();
    check("t3_free_b", OC_Free_EntryNum, 3);
    alloc(1, 1, pl(13));
    cyc();
    check("t3_full", OC_Full, 1);
    rf_set(0, 2, 0, dpat(2, 1));
    rf_set(1, 2, 1, dpat(2, 2));
    cyc();
    check("t3_entry", OC_Issue_EntryNum, 2);
    push(2, dpat(2, 1), dpat(2, 2), pl(12));
    issue_one();
    check("t3_full_after", OC_Full, 0);
    check("t3_free_after", OC_Free_EntryNum, 2);

    // Multi-bank captures in one cycle.
    alloc(1, 1, pl(22));
    cyc();
    check("t4_full", OC_Full, 1);
    rf_set(0, 1, 0, dpat(1, 1));
    rf_set(3, 1, 1, dpat(1, 2));
    rf_set(1, 3, 0, dpat(3, 1));
    cyc();
    check("t4_valid", OC_Issue_Valid, 1);
    check("t4_entry", OC_Issue_EntryNum, 1);
    push(1, dpat(1, 1), dpat(1, 2), pl(2));
    issue_one();
    check("t4_e3_half", OC_Issue_Valid, 0);
    alloc(0, 0, pl(31));
    cyc();
    check("t4_e1_offer", OC_Issue_EntryNum, 1);
    check("t4_e1_pl", OC_Issue_Payload, pl(31));

    // Asynchronous reset while entry 1 is offered.
    rst_n = 1'b0;
    #1;
    check("rst2_valid", OC_Issue_Valid, 0);
    check("rst2_full", OC_Full, 0);
    check("rst2_free", OC_Free_EntryNum, 0);
    check("rst2_payload", OC_Issue_Payload, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    check("rst2_valid_after", OC_Issue_Valid, 0);

    // All four ready, stall three cycles, then drain.
    for (int e = 0; e < 4; e++) begin
      alloc(1, 1, pl(40 + e));
      cyc();
    end
    check("t5_full", OC_Full, 1);
    rf_set(0, 0, 0, dpat(0, 1));
    rf_set(1, 0, 1, dpat(0, 2));
    rf_set(2, 1, 0, dpat(1, 1));
    rf_set(3, 1, 1, dpat(1, 2));
    cyc();
    rf_set(0, 2, 0, dpat(2, 1));
    rf_set(1, 2, 1, dpat(2, 2));
    rf_set(2, 3, 0, dpat(3, 1));
    rf_set(3, 3, 1, dpat(3, 2));
    cyc();
    for (int k = 0; k < 3; k++) begin
      check("t5_stall_entry", OC_Issue_EntryNum, 0);
      check("t5_stall_src1", OC_Issue_Src1, dpat(0, 1));
      check("t5_stall_src2", OC_Issue_Src2, dpat(0, 2));
      check("t5_stall_pl", OC_Issue_Payload, pl(40));
      cyc();
    end
    for (int e = 0; e < 4; e++) push(e, dpat(e, 1), dpat(e, 2), pl(40 + e));
    EX_Ready = 1'b1;
    repeat (4) cyc();
    EX_Ready = 1'b0;
    check("t5_drained", OC_Issue_Valid, 0);
    check("t5_full_after", OC_Full, 0);

    // Entry 0 issued last, then entries 0 and 2 become ready together.
    alloc(0, 0, pl(50));
    cyc();
    push(0, '0, '0, pl(50));
    issue_one();
    alloc(1, 1, pl(51));
    cyc();
    alloc(1, 1, pl(52));
    cyc();
    alloc(1, 1, pl(53));
    cyc();
    rf_set(0, 0, 0, dpat(0, 3));
    rf_set(1, 0, 1, dpat(0, 4));
    rf_set(2, 2, 0, dpat(2, 3));
    rf_set(3, 2, 1, dpat(2, 4));
    cyc();
`ifdef OC_RR_ARB_EN
    check("t6_first", OC_Issue_EntryNum, 2);
    push(2, dpat(2, 3), dpat(2, 4), pl(53));
    push(0, dpat(0, 3), dpat(0, 4), pl(51));
`else
    check("t6_first", OC_Issue_EntryNum, 0);
    push(0, dpat(0, 3), dpat(0, 4), pl(51));
    push(2, dpat(2, 3), dpat(2, 4), pl(53));
`endif
    EX_Ready = 1'b1;
    repeat (2) cyc();
    EX_Ready = 1'b0;
    rf_set(3, 1, 0, dpat(1, 3));
    rf_set(0, 1, 1, dpat(1, 4));
    cyc();
    push(1, dpat(1, 3), dpat(1, 4), pl(52));
    issue_one();
    cyc();
    check("sb_empty", sb_q.size(), 0);
    check("end_full", OC_Full, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
